// File: rtl/gate_tt_pkg.sv
// -----------------------------------------------------------------------------
// gate_tt_pkg
// Shared definitions for the two-input gate truth-table checker.
//   state_t   : checker sequencer states
//   TT_*      : 4-bit truth tables indexed by {a,b} (bit 0 is a=0,b=0)
// -----------------------------------------------------------------------------
package gate_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage : gate_tt_pkg

// File: rtl/gate_tt_checker.sv
// -----------------------------------------------------------------------------
// gate_tt_checker
// Drives the four input combinations 00,01,10,11 onto an external two-input
// gate, holds each for SETTLE_CYCLES cycles plus one sampling cycle, and
// compares the gate output against a latched 4-bit expected truth table.
//
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   start       : run request, looked at only while idle
//   expected_tt : expected gate output per vector, latched when start is taken
//   gate_y      : output of the gate under test
//   gate_a/b    : stimulus to the gate under test
//   busy        : high while vectors are being driven/sampled
//   done        : one-cycle pulse, results valid from this cycle
//   pass        : no mismatches in the completed run
//   err_mask    : bit i set when vector i mismatched
//   err_count   : number of mismatching vectors, 0..4
//
// Handshake: start is a request level sampled only in IDLE; the edge at which
// it is seen in IDLE accepts the run. No acknowledge is given other than busy
// rising the next cycle; done pulses for exactly one cycle at completion, and
// results hold until the next accepted start.
//
// The sequencer state is available as the internal signal `state` for
// observation.
// -----------------------------------------------------------------------------
module gate_tt_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected_tt,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);
    import gate_tt_pkg::*;

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("gate_tt_checker: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_d;
    logic [1:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       tt_q, tt_d;
    logic [3:0]       mask_d;
    logic [2:0]       count_d;
    logic             pass_d;
    logic             gate_a_d, gate_b_d, busy_d, done_d;
    logic             miss;

    // Case-inequality so that an X/Z from the gate counts as a mismatch.
    assign miss = (gate_y !== tt_q[idx]);

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt;
        tt_d     = tt_q;
        mask_d   = err_mask;
        count_d  = err_count;
        pass_d   = pass;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    tt_d    = expected_tt;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    mask_d  = 4'b0000;
                    count_d = 3'd0;
                    pass_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (miss) begin
                    mask_d[idx] = 1'b1;
                    count_d     = err_count + 3'd1;
                end
                if (idx == 2'd3) begin
                    // pass must already reflect the last vector in the DONE cycle
                    pass_d  = (count_d == 3'd0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx + 2'd1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        busy_d   = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d   = (state_d == ST_DONE);
        gate_a_d = busy_d & idx_d[1];
        gate_b_d = busy_d & idx_d[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            cnt       <= '0;
            tt_q      <= 4'b0000;
            err_mask  <= 4'b0000;
            err_count <= 3'd0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            tt_q      <= tt_d;
            err_mask  <= mask_d;
            err_count <= count_d;
            pass      <= pass_d;
            busy      <= busy_d;
            done      <= done_d;
            gate_a    <= gate_a_d;
            gate_b    <= gate_b_d;
        end
    end

endmodule : gate_tt_checker

// File: doc/gate_tt_checker.md
# gate_tt_checker

Self-checking truth-table sequencer for the two-input basic-gate library. On `start` it drives all four input combinations (00, 01, 10, 11) onto an external gate and lets each one settle. It then samples the gate output and compares it against a 4-bit expected truth table. It reports pass/fail, a per-vector error mask and an error count. It sits opposite a gate under test, replacing hand-written stimulus/monitor benches, and is synthesizable for on-board gate self-test.

## Interface
- `SETTLE_CYCLES`, default 2: cycles a vector is held before the sampling cycle. Legal range ≥1; a value of 0 is an elaboration error.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `expected_tt`  in  4  expected output, bit index = {a,b}; `expected_tt[0]` is for a=0,b=0. Latched at start.
- `gate_y`  in  1  output of the gate under test.
- `gate_a`, `gate_b`  out  1 each  stimulus to the gate under test.
- `busy`  out  1  high from the cycle after start is accepted through the last SAMPLE cycle.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `pass`  out  1  high when `err_count` == 0 after a completed run.
- `err_mask`  out  4  bit i set when vector i mismatched.
- `err_count`  out  3  number of mismatches, 0..4.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- **IDLE**
  - `start`=1 → latch `expected_tt`, idx=0, cnt=0, clear `pass`/`err_mask`/`err_count`, go to WAIT.
  - `start` is ignored in every other state.
- **WAIT**
  - `{gate_a,gate_b}` = idx.
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1, go to SAMPLE.
- **SAMPLE**
  - `{gate_a,gate_b}` still = idx.
  - At the clock edge ending the cycle, compare `gate_y` with `tt_q[idx]`.
  - On mismatch, set `err_mask[idx]` and increment `err_count`.
  - idx==3 → DONE; else idx+1, cnt=0, go to WAIT.
- **DONE**
  - `done`=1 for this cycle; `pass` = (`err_count` == 0) with the final result included.
  - Return to IDLE. `start` presented in DONE is ignored.
- Results (`pass`, `err_mask`, `err_count`) hold until the next accepted start.
- `gate_a`/`gate_b` return to 0 in DONE and IDLE.
- `expected_tt` changes after acceptance have no effect on the run in progress.
- An X/Z on `gate_y` counts as a mismatch in simulation: the comparison treats a non-0/1 value as unequal.
- idx is 2 bits and never wraps mid-run; termination is decided at idx==3.

## Timing
- All outputs reset to 0 asynchronously; state → IDLE, idx/cnt → 0.
- Reset mid-run aborts immediately: no `done`, results cleared, and the next start runs a full sequence.
- With start accepted at edge T, vector 00 is driven from cycle T+1.
- Each vector is held SETTLE_CYCLES+1 cycles.
- `done` is high in cycle T+1+4·(SETTLE_CYCLES+1).
- `busy` is high for exactly 4·(SETTLE_CYCLES+1) cycles.
- The earliest next start is accepted in the cycle after `done`.
- `gate_y` must be stable by the edge ending SAMPLE. The gate under test is combinational, or has latency < SETTLE_CYCLES.
- All outputs are registered; none is combinational from `gate_y` or `start`.

## Structure
- Shared package `gate_tt_pkg`:
  - state enum;
  - truth-table constants TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- Single module. The settle counter is small enough to stay inline, so no sub-module.
- The bench instantiates `gate_tt_checker` around the existing structural/dataflow gate modules.

## Test plan
- NAND gate, `expected_tt`=TT_NAND, SETTLE_CYCLES=2, start at T → `gate_a`/`gate_b` sequence 00,01,10,11, 3 cycles each; `done` at T+13; `pass`=1, `err_mask`=0000, `err_count`=0.
- NAND gate, `expected_tt`=TT_AND → `err_mask`=1111, `err_count`=4, `pass`=0.
- `gate_y` stuck-at-1, `expected_tt`=TT_NAND → `err_mask`=1000, `err_count`=1, `pass`=0.
- Pulse `start` again mid-run and change `expected_tt` to TT_OR mid-run → ignored; `done` still at T+13 with the TT_NAND result; results hold afterwards; `start` presented in the DONE cycle is also ignored.
- Assert `rst` during vector 01 → all outputs 0 at once, no `done`; a subsequent start completes a full passing run.
- Back-to-back runs: start accepted in the cycle after `done`, with a gate stuck-at-0 → first results cleared at acceptance; final `err_mask`=0111, `err_count`=3.
